rdcnt_unit: RTL and testbench
=============================

Name: rdcnt_unit

Overview:
- Execution unit for LoongArch RDCNT instructions (RDCNTVL.W, RDCNTVH.W, RDCNTID).
- Owns the 64-bit stable counter and the counter-ID (TID) register.
- Arbitrates RDCNT requests from NUM_REQ issue lanes and returns one 32-bit writeback per accepted op.
- Sits after the RDCNT decoder: each lane supplies the decoder's 2-bit rdcnt_op_type plus a destination register.

Parameters:
- NUM_REQ, 2: number of requesting issue lanes (1..4).
- DIV, 1: stable counter increments once every DIV clocks (1..256).
- TID_RST, 32'h0: reset value of TID.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-lane request valid.
- req_op  in  2*NUM_REQ  per-lane op; lane i at [2i+1:2i]; codes are the `INVALID_OP_2B / `RDCNT_RDCNTVL / `RDCNT_RDCNTVH / `RDCNT_RDCNTID macros from defs.sv.
- req_rd  in  5*NUM_REQ  per-lane destination register; lane i at [5i+4:5i].
- req_ready  out  NUM_REQ  per-lane grant; the request is consumed on req_valid & req_ready.
- resp_valid  out  1  writeback valid.
- resp_ready  in  1  writeback accepted by the commit stage.
- resp_data  out  32  result value.
- resp_rd  out  5  destination register.
- resp_src  out  2  lane index of the result.
- flush  in  1  pipeline flush.
- cnt_halt  in  1  debug freeze of the counter.
- tid_we  in  1  CSR write strobe for TID.
- tid_wdata  in  32  TID write data.
- cnt_value  out  64  current stable counter value (for CSR readout).

Behaviour:
- Reset (rst=1 at a clk edge): cnt=0, prescaler=0, TID=TID_RST, rr_ptr=0, resp stage EMPTY.
  - resp_valid=0, resp_data=0, resp_rd=0, resp_src=0, req_ready=0.
- Prescaler:
  - Counts 0..DIV-1 while cnt_halt=0; cnt increments when the prescaler wraps to 0.
  - With DIV=1, cnt increments every cycle.
  - cnt wraps from 2^64-1 to 0.
  - cnt_halt=1 freezes both cnt and the prescaler.
- TID: updated from tid_wdata on tid_we; takes effect the next cycle.
- Response stage is a 2-state FSM (EMPTY/FULL).
  - can_accept = (EMPTY | resp_ready) & ~flush.
- Arbitration:
  - Round-robin starting at rr_ptr.
  - When can_accept=1, exactly one valid lane is granted (req_ready one-hot); all others are 0.
  - After a grant to lane g, rr_ptr becomes (g+1) mod NUM_REQ.
  - With no grant, rr_ptr is unchanged.
  - req_ready is combinational from req_valid, rr_ptr and can_accept.
- Result values, sampled in the grant cycle:
  - VL: cnt[31:0].
  - VH: cnt[63:32].
  - ID: TID.
  - Values are taken before this cycle's increment or TID write, so tid_we in the grant cycle still returns the old TID.
- Latency: a grant in cycle N gives resp_valid=1 in cycle N+1 with the data, rd and lane registered.
- Invalid op: the lane is granted and consumed, but no response is produced; the stage does not become FULL from it.
- FULL & ~resp_ready: all resp_* outputs hold stable; req_ready stays 0 for all lanes.
- FULL & resp_ready & new grant: the stage stays FULL with the new result (back-to-back throughput of 1/cycle).
- FULL & resp_ready & no grant: the stage goes to EMPTY.
- flush:
  - Stage goes to EMPTY next cycle and the pending response is dropped.
  - No grant in the flush cycle.
  - cnt, TID and rr_ptr are unaffected.
- rst asserted mid-operation overrides everything, including flush and a pending response.

Optional Feature:
- RDCNT_SNAPSHOT_EN defined:
  - Each lane has a snapshot register plus a valid bit.
  - A VL grant latches cnt[63:32] (same sample as the VL data) and sets the lane's valid bit.
  - A VH grant from a lane with its valid bit set returns the snapshot and clears the bit.
  - This makes a VL→VH pair atomic across a carry out of the low word.
  - flush and rst clear all valid bits.
  - VH with the valid bit clear returns live cnt[63:32].
- Undefined: no snapshot storage; VH always returns live cnt[63:32].

Test Plan:
- Reset, then 10 idle cycles with DIV=1 → cnt_value=10 and resp_valid=0 throughout.
- Lanes 0 and 1 both request VL continuously, resp_ready=1 → grants alternate 0,1,0,1; one resp per cycle; resp_src alternates; resp_data increments by 1 each response.
- Preload cnt to 64'h0000_0000_FFFF_FFFF; lane 0 issues VL then VH on consecutive grants:
  - Without the macro → 32'hFFFF_FFFF, then 32'h1.
  - With RDCNT_SNAPSHOT_EN → 32'hFFFF_FFFF, then 32'h0.
- tid_we with tid_wdata=32'hA5 in the same cycle as an ID grant → resp_data=TID_RST; the next ID grant → 32'hA5.
- resp_ready held 0 for 5 cycles with both lanes requesting → resp_* stable and req_ready=0; after release, the pending response retires and the next lane in round-robin order is granted.
- flush while FULL with lane 1 requesting → resp_valid=0 next cycle, no grant in the flush cycle; lane 1 granted the cycle after. Separately, an invalid-op request → consumed with no response.

Source files
------------

// File: rtl/rdcnt_unit.sv
// ============================================================================
//  Module      : rdcnt_unit
//  Description : Execution unit for the LoongArch RDCNT instructions
//                (RDCNTVL.W / RDCNTVH.W / RDCNTID). Owns the 64-bit stable
//                counter and the TID register, arbitrates NUM_REQ issue lanes
//                round-robin and returns one registered 32-bit writeback per
//                accepted op.
//                Optional macro RDCNT_SNAPSHOT_EN: per-lane high-word snapshot
//                taken on VL so that a following VH from the same lane is
//                consistent with it across a low-word carry.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef INVALID_OP_2B
`define INVALID_OP_2B 2'b00
`endif
`ifndef RDCNT_RDCNTVL
`define RDCNT_RDCNTVL 2'b01
`endif
`ifndef RDCNT_RDCNTVH
`define RDCNT_RDCNTVH 2'b10
`endif
`ifndef RDCNT_RDCNTID
`define RDCNT_RDCNTID 2'b11
`endif

module rdcnt_unit #(
    parameter int          NUM_REQ = 2,
    parameter int          DIV     = 1,
    parameter logic [31:0] TID_RST = 32'h0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [2*NUM_REQ-1:0] req_op,
    input  logic [5*NUM_REQ-1:0] req_rd,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_data,
    output logic [4:0]           resp_rd,
    output logic [1:0]           resp_src,
    input  logic                 flush,
    input  logic                 cnt_halt,
    input  logic                 tid_we,
    input  logic [31:0]          tid_wdata,
    output logic [63:0]          cnt_value
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PSC_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PSC_W-1:0] c_PSC_MAX = PSC_W'(DIV - 1);
    localparam logic [PTR_W-1:0] c_PTR_MAX = PTR_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t             r_state;
    logic [63:0]        r_cnt;
    logic [PSC_W-1:0]   r_psc;
    logic [31:0]        r_tid;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [31:0]        r_resp_data;
    logic [4:0]         r_resp_rd;
    logic [1:0]         r_resp_src;

    logic               w_can_accept;
    logic [NUM_REQ-1:0] w_grant;
    logic [PTR_W-1:0]   w_gidx;
    logic               w_gany;
    logic [1:0]         w_op;
    logic [4:0]         w_rd;
    logic               w_op_valid;
    logic [31:0]        w_hi_word;
    logic [31:0]        w_data;

    // Prescaler and stable counter; cnt_halt freezes both.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 64'd0;
            r_psc <= '0;
        end else if (!cnt_halt) begin
            if (r_psc == c_PSC_MAX) begin
                r_psc <= '0;
                r_cnt <= r_cnt + 64'd1;
            end else begin
                r_psc <= r_psc + 1'b1;
            end
        end
    end

    // TID register, written by the CSR path.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tid <= TID_RST;
        end else if (tid_we) begin
            r_tid <= tid_wdata;
        end
    end

    // A new op may enter when the output slot is free or being retired.
    assign w_can_accept = ~rst & ~flush & ((r_state == S_EMPTY) | resp_ready);

    // Round-robin scan starting at rr_ptr; the first valid lane wins.
    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        w_grant = '0;
        w_gidx  = '0;
        w_gany  = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (w_can_accept && !w_gany && req_valid[idx]) begin
                w_gany       = 1'b1;
                w_gidx       = idx;
                w_grant[idx] = 1'b1;
            end
        end
    end

    assign req_ready = w_grant;

    // Select the granted lane's op and destination register.
    always_comb begin
        w_op = `INVALID_OP_2B;
        w_rd = 5'd0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_grant[j]) begin
                w_op = req_op[2*j +: 2];
                w_rd = req_rd[5*j +: 5];
            end
        end
    end

    assign w_op_valid = (w_op != `INVALID_OP_2B);

`ifdef RDCNT_SNAPSHOT_EN
    logic [31:0]        r_snap [NUM_REQ];
    logic [NUM_REQ-1:0] r_snap_vld;
    logic               w_snap_hit;
    logic [31:0]        w_snap_val;

    // Pick the granted lane's snapshot, if it holds one.
    always_comb begin
        w_snap_hit = 1'b0;
        w_snap_val = 32'd0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_grant[j]) begin
                w_snap_hit = r_snap_vld[j];
                w_snap_val = r_snap[j];
            end
        end
    end

    assign w_hi_word = w_snap_hit ? w_snap_val : r_cnt[63:32];

    // VL captures the high word; the next VH from that lane consumes it.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_snap_vld <= '0;
        end else begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (w_grant[j] && (w_op == `RDCNT_RDCNTVL)) begin
                    r_snap[j]     <= r_cnt[63:32];
                    r_snap_vld[j] <= 1'b1;
                end else if (w_grant[j] && (w_op == `RDCNT_RDCNTVH)) begin
                    r_snap_vld[j] <= 1'b0;
                end
            end
        end
    end
`else
    assign w_hi_word = r_cnt[63:32];
`endif

    // Result value, sampled before this cycle's counter/TID update.
    always_comb begin
        w_data = 32'd0;
        case (w_op)
            `RDCNT_RDCNTVL: w_data = r_cnt[31:0];
            `RDCNT_RDCNTVH: w_data = w_hi_word;
            `RDCNT_RDCNTID: w_data = r_tid;
            default:        w_data = 32'd0;
        endcase
    end

    // Round-robin pointer moves past the lane just granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_gany) begin
            r_rr_ptr <= (w_gidx == c_PTR_MAX) ? '0 : w_gidx + 1'b1;
        end
    end

    // Response stage FSM with registered writeback fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_resp_data <= 32'd0;
            r_resp_rd   <= 5'd0;
            r_resp_src  <= 2'd0;
        end else if (flush) begin
            r_state <= S_EMPTY;
        end else if (w_gany && w_op_valid) begin
            r_state     <= S_FULL;
            r_resp_data <= w_data;
            r_resp_rd   <= w_rd;
            r_resp_src  <= 2'(w_gidx);
        end else if ((r_state == S_FULL) && resp_ready) begin
            r_state <= S_EMPTY;
        end
    end

    assign resp_valid = (r_state == S_FULL);
    assign resp_data  = r_resp_data;
    assign resp_rd    = r_resp_rd;
    assign resp_src   = r_resp_src;
    assign cnt_value  = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_rdcnt_unit.sv
// ============================================================================
//  Module      : tb_rdcnt_unit
//  Description : Directed self-checking bench for rdcnt_unit (NUM_REQ=2,
//                DIV=1, TID_RST=32'h1234_5678).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef INVALID_OP_2B
`define INVALID_OP_2B 2'b00
`endif
`ifndef RDCNT_RDCNTVL
`define RDCNT_RDCNTVL 2'b01
`endif
`ifndef RDCNT_RDCNTVH
`define RDCNT_RDCNTVH 2'b10
`endif
`ifndef RDCNT_RDCNTID
`define RDCNT_RDCNTID 2'b11
`endif

module tb_rdcnt_unit;

    localparam logic [31:0] c_TID_RST = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [3:0]  req_op = 4'b0000;
    logic [9:0]  req_rd = {5'd9, 5'd3};
    logic [1:0]  req_ready;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic [1:0]  resp_src;
    logic        flush = 1'b0;
    logic        cnt_halt = 1'b0;
    logic        tid_we = 1'b0;
    logic [31:0] tid_wdata = 32'h0;
    logic [63:0] cnt_value;

    int vectors = 0;
    int errors  = 0;

    rdcnt_unit #(
        .NUM_REQ (2),
        .DIV     (1),
        .TID_RST (c_TID_RST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_rd     (req_rd),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_rd    (resp_rd),
        .resp_src   (resp_src),
        .flush      (flush),
        .cnt_halt   (cnt_halt),
        .tid_we     (tid_we),
        .tid_wdata  (tid_wdata),
        .cnt_value  (cnt_value)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 2'b11;
        req_op    = {`RDCNT_RDCNTVL, `RDCNT_RDCNTVL};
        tick();
        tick();
        vectors++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
        vectors++; if (resp_data !== 32'd0) begin errors++; $display("FAIL rst_resp_data got %h want 0", resp_data); end
        vectors++; if (resp_rd !== 5'd0) begin errors++; $display("FAIL rst_resp_rd got %h want 0", resp_rd); end
        vectors++; if (resp_src !== 2'd0) begin errors++; $display("FAIL rst_resp_src got %h want 0", resp_src); end
        vectors++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready got %b want 00", req_ready); end
        vectors++; if (cnt_value !== 64'd0) begin errors++; $display("FAIL rst_cnt got %h want 0", cnt_value); end
        rst       = 1'b0;
        req_valid = 2'b00;
    endtask

    task automatic test_idle_count();
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL idle_resp_valid cyc %0d got %b want 0", i, resp_valid); end
        end
        vectors++; if (cnt_value !== 64'd10) begin errors++; $display("FAIL idle_cnt got %0d want 10", cnt_value); end
    endtask

    task automatic test_round_robin();
        req_valid  = 2'b11;
        req_op     = {`RDCNT_RDCNTVL, `RDCNT_RDCNTVL};
        req_rd     = {5'd7, 5'd5};
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++; if (req_ready !== ((i % 2) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_ready step %0d got %b", i, req_ready); end
            tick();
            vectors++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL rr_valid step %0d got %b want 1", i, resp_valid); end
            vectors++; if (resp_data !== 32'(10 + i)) begin errors++; $display("FAIL rr_data step %0d got %0d want %0d", i, resp_data, 10 + i); end
            vectors++; if (resp_src !== 2'(i % 2)) begin errors++; $display("FAIL rr_src step %0d got %0d want %0d", i, resp_src, i % 2); end
            vectors++; if (resp_rd !== ((i % 2) ? 5'd7 : 5'd5)) begin errors++; $display("FAIL rr_rd step %0d got %0d", i, resp_rd); end
        end
        req_valid = 2'b00;
        req_rd    = {5'd9, 5'd3};
        tick();
        vectors++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got %b want 0", resp_valid); end
    endtask

    task automatic test_carry();
        cnt_halt = 1'b1;
        tick();
        force dut.r_cnt = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.r_cnt;
        tick();
        tick();
        tick();
        vectors++; if (cnt_value !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("FAIL halt_cnt got %h want 00000000ffffffff", cnt_value); end
        cnt_halt  = 1'b0;
        req_valid = 2'b01;
        req_op    = {`INVALID_OP_2B, `RDCNT_RDCNTVL};
        tick();
        vectors++; if (resp_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL carry_vl got %h want ffffffff", resp_data); end
        vectors++; if (cnt_value !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL carry_cnt got %h want 0000000100000000", cnt_value); end
        req_op = {`INVALID_OP_2B, `RDCNT_RDCNTVH};
        #1;
        vectors++; if (req_ready !== 2'b01) begin errors++; $display("FAIL carry_ready got %b want 01", req_ready); end
        tick();
`ifdef RDCNT_SNAPSHOT_EN
        vectors++; if (resp_data !== 32'h0) begin errors++; $display("FAIL carry_vh got %h want 00000000", resp_data); end
`else
        vectors++; if (resp_data !== 32'h1) begin errors++; $display("FAIL carry_vh got %h want 00000001", resp_data); end
`endif
        vectors++; if (cnt_value !== 64'h0000_0001_0000_0001) begin errors++; $display("FAIL carry_cnt2 got %h want 0000000100000001", cnt_value); end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_tid();
        req_valid = 2'b01;
        req_op    = {`INVALID_OP_2B, `RDCNT_RDCNTID};
        tid_we    = 1'b1;
        tid_wdata = 32'hA5;
        tick();
        tid_we = 1'b0;
        vectors++; if (resp_data !== c_TID_RST) begin errors++; $display("FAIL tid_old got %h want %h", resp_data, c_TID_RST); end
        tick();
        vectors++; if (resp_data !== 32'hA5) begin errors++; $display("FAIL tid_new got %h want 000000a5", resp_data); end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_stall();
        resp_ready = 1'b0;
        req_valid  = 2'b11;
        req_op     = {`RDCNT_RDCNTID, `RDCNT_RDCNTID};
        #1;
        vectors++; if (req_ready !== 2'b10) begin errors++; $display("FAIL stall_first_ready got %b want 10", req_ready); end
        tick();
        for (int i = 0; i < 6; i++) begin
            vectors++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL stall_valid cyc %0d got %b want 1", i, resp_valid); end
            vectors++; if (resp_src !== 2'd1) begin errors++; $display("FAIL stall_src cyc %0d got %0d want 1", i, resp_src); end
            vectors++; if (resp_rd !== 5'd9) begin errors++; $display("FAIL stall_rd cyc %0d got %0d want 9", i, resp_rd); end
            vectors++; if (resp_data !== 32'hA5) begin errors++; $display("FAIL stall_data cyc %0d got %h want a5", i, resp_data); end
            vectors++; if (req_ready !== 2'b00) begin errors++; $display("FAIL stall_ready cyc %0d got %b want 00", i, req_ready); end
            if (i < 5) tick();
        end
        resp_ready = 1'b1;
        #1;
        vectors++; if (req_ready !== 2'b01) begin errors++; $display("FAIL stall_release_ready got %b want 01", req_ready); end
        tick();
        vectors++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL stall_next_valid got %b want 1", resp_valid); end
        vectors++; if (resp_src !== 2'd0) begin errors++; $display("FAIL stall_next_src got %0d want 0", resp_src); end
        vectors++; if (resp_rd !== 5'd3) begin errors++; $display("FAIL stall_next_rd got %0d want 3", resp_rd); end
        req_valid = 2'b00;
        tick();
        vectors++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got %b want 0", resp_valid); end
    endtask

    task automatic test_flush();
        resp_ready = 1'b0;
        req_valid  = 2'b01;
        req_op     = {`RDCNT_RDCNTID, `RDCNT_RDCNTID};
        #1;
        vectors++; if (req_ready !== 2'b01) begin errors++; $display("FAIL flush_fill_ready got %b want 01", req_ready); end
        tick();
        vectors++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL flush_fill_valid got %b want 1", resp_valid); end
        req_valid = 2'b10;
        flush     = 1'b1;
        #1;
        vectors++; if (req_ready !== 2'b00) begin errors++; $display("FAIL flush_cycle_ready got %b want 00", req_ready); end
        tick();
        flush = 1'b0;
        vectors++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got %b want 0", resp_valid); end
        #1;
        vectors++; if (req_ready !== 2'b10) begin errors++; $display("FAIL flush_after_ready got %b want 10", req_ready); end
        tick();
        vectors++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL flush_lane1_valid got %b want 1", resp_valid); end
        vectors++; if (resp_src !== 2'd1) begin errors++; $display("FAIL flush_lane1_src got %0d want 1", resp_src); end
        resp_ready = 1'b1;
        req_valid  = 2'b00;
        tick();
    endtask

    task automatic test_invalid_op();
        req_valid = 2'b01;
        req_op    = {`RDCNT_RDCNTID, `INVALID_OP_2B};
        #1;
        vectors++; if (req_ready !== 2'b01) begin errors++; $display("FAIL inv_ready got %b want 01", req_ready); end
        tick();
        vectors++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL inv_no_resp got %b want 0", resp_valid); end
        req_valid = 2'b11;
        #1;
        vectors++; if (req_ready !== 2'b10) begin errors++; $display("FAIL inv_rr_advance got %b want 10", req_ready); end
        tick();
        vectors++; if (resp_src !== 2'd1) begin errors++; $display("FAIL inv_next_src got %0d want 1", resp_src); end
        vectors++; if (resp_data !== 32'hA5) begin errors++; $display("FAIL inv_next_data got %h want a5", resp_data); end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_mid_reset();
        resp_ready = 1'b0;
        req_valid  = 2'b01;
        req_op     = {`RDCNT_RDCNTID, `RDCNT_RDCNTID};
        tick();
        rst   = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vectors++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", resp_valid); end
        vectors++; if (req_ready !== 2'b00) begin errors++; $display("FAIL midrst_ready got %b want 00", req_ready); end
        vectors++; if (cnt_value !== 64'd0) begin errors++; $display("FAIL midrst_cnt got %h want 0", cnt_value); end
        req_valid  = 2'b00;
        resp_ready = 1'b1;
        rst        = 1'b0;
        tick();
        req_valid = 2'b01;
        req_op    = {`INVALID_OP_2B, `RDCNT_RDCNTID};
        tick();
        vectors++; if (resp_data !== c_TID_RST) begin errors++; $display("FAIL midrst_tid got %h want %h", resp_data, c_TID_RST); end
        req_valid = 2'b00;
        tick();
    endtask

    initial begin
        test_reset();
        test_idle_count();
        test_round_robin();
        test_carry();
        test_tid();
        test_stall();
        test_flush();
        test_invalid_op();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
